// File: rtl/vx_mask_sequencer.sv
// rtl/vx_mask_sequencer.sv - serialises a lane mask into a stream of set-bit indices
// One beat per set bit, lowest-first (MODE=0) or highest-first (MODE=1), tag echoed on every beat.
module vx_mask_sequencer #(
  parameter  int WIDTH     = 8,
  parameter  int MODE      = 0,
  parameter  int TAG_WIDTH = 4,
  localparam int LIDX      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_mask,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LIDX-1:0]      out_index,
  output logic                 out_last,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;

  logic [LIDX-1:0]  idx_c;
  logic [WIDTH-1:0] clr_c;
  logic             single_c;
  logic             in_fire;
  logic             out_fire;
  logic             load_ok;

  // Priority encoder: the last match in scan order wins, so scan away from the preferred end.
  always_comb begin
    idx_c = '0;
    if (MODE == 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (rem_q[i]) idx_c = LIDX'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (rem_q[i]) idx_c = LIDX'(i);
      end
    end
  end

  assign clr_c    = WIDTH'(1) << idx_c;
  assign single_c = ((rem_q & (rem_q - WIDTH'(1))) == '0);

  assign busy      = (state_q == BUSY);
  assign out_valid = busy;
  assign out_index = idx_c;
  assign out_last  = busy & single_c;
  assign out_tag   = tag_q;

  assign out_fire = out_valid & out_ready;
  assign in_ready = ~busy | (out_fire & out_last);
  assign in_fire  = in_valid & in_ready;
  assign load_ok  = in_fire & (in_mask != '0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tag_d   = tag_q;
    if (state_q == IDLE) begin
      if (load_ok) begin
        state_d = BUSY;
        rem_d   = in_mask;
        tag_d   = in_tag;
      end
    end else if (out_fire) begin
      if (!out_last) begin
        rem_d = rem_q & ~clr_c;
      end else if (load_ok) begin
        rem_d = in_mask;
        tag_d = in_tag;
      end else begin
        state_d = IDLE;
        rem_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_vx_mask_sequencer.sv
// tb/tb_vx_mask_sequencer.sv - directed and scoreboard checks for vx_mask_sequencer
// Two 8-bit DUTs (MODE 0 and 1) share stimulus; a WIDTH=1 DUT covers the degenerate case.
module tb_vx_mask_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_mask;
  logic [3:0] in_tag;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [2:0] a_out_index;
  logic [3:0] a_out_tag;
  logic       b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [2:0] b_out_index;
  logic [3:0] b_out_tag;

  logic       w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_last, w_busy;
  logic [0:0] w_in_mask;
  logic [0:0] w_out_index;
  logic [3:0] w_in_tag, w_out_tag;

  int checks = 0;
  int errors = 0;

  vx_mask_sequencer #(.WIDTH(8), .MODE(0), .TAG_WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_mask(in_mask), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_index(a_out_index), .out_last(a_out_last), .out_tag(a_out_tag), .busy(a_busy)
  );

  vx_mask_sequencer #(.WIDTH(8), .MODE(1), .TAG_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_mask(in_mask), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_index(b_out_index), .out_last(b_out_last), .out_tag(b_out_tag), .busy(b_busy)
  );

  vx_mask_sequencer #(.WIDTH(1), .MODE(0), .TAG_WIDTH(4)) dut_w (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_mask(w_in_mask), .in_tag(w_in_tag), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_index(w_out_index), .out_last(w_out_last), .out_tag(w_out_tag), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0; in_mask = '0; in_tag = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_mask = '0; w_in_tag = '0; w_out_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ctrl_a: valid=%b busy=%b ready=%b expected 0 0 1", a_out_valid, a_busy, a_in_ready); end
    checks++; if (a_out_index !== 3'd0 || a_out_last !== 1'b0 || a_out_tag !== 4'd0) begin
      errors++; $display("FAIL reset_data_a: idx=%0d last=%b tag=%0d expected 0 0 0", a_out_index, a_out_last, a_out_tag); end
    checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_b_w: b_valid=%b b_ready=%b w_valid=%b w_ready=%b expected 0 1 0 1", b_out_valid, b_in_ready, w_out_valid, w_in_ready); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int e0[4] = '{1, 2, 5, 7};
    int e1[4] = '{7, 5, 2, 1};
    @(negedge clk);
    in_valid = 1'b1; in_mask = 8'hA6; in_tag = 4'd3; out_ready = 1'b1; #1;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_accept: ready=%b valid=%b expected 1 0", a_in_ready, a_out_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      checks++; if (a_out_valid !== 1'b1 || a_out_index !== e0[k] || a_out_last !== (k == 3) || a_out_tag !== 4'd3) begin
        errors++; $display("FAIL basic_mode0 beat %0d: v=%b idx=%0d last=%b tag=%0d expected 1 %0d %0d 3", k, a_out_valid, a_out_index, a_out_last, a_out_tag, e0[k], k == 3); end
      checks++; if (b_out_valid !== 1'b1 || b_out_index !== e1[k] || b_out_last !== (k == 3) || b_out_tag !== 4'd3) begin
        errors++; $display("FAIL basic_mode1 beat %0d: v=%b idx=%0d last=%b tag=%0d expected 1 %0d %0d 3", k, b_out_valid, b_out_index, b_out_last, b_out_tag, e1[k], k == 3); end
      checks++; if (a_in_ready !== (k == 3)) begin
        errors++; $display("FAIL basic_in_ready beat %0d: got %b expected %0d", k, a_in_ready, k == 3); end
    end
    @(negedge clk); #1;
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle: valid=%b busy_a=%b busy_b=%b expected 0 0 0", a_out_valid, a_busy, b_busy); end
  endtask

  task automatic test_back_to_back;
    int ea[3] = '{0, 7, 4};
    int eb[3] = '{7, 0, 4};
    int et[3] = '{5, 5, 6};
    @(negedge clk);
    in_valid = 1'b1; in_mask = 8'h81; in_tag = 4'd5; out_ready = 1'b1;
    @(negedge clk);
    in_mask = 8'h10; in_tag = 4'd6;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin @(negedge clk); in_valid = 1'b0; end
      else if (k == 1) @(negedge clk);
      #1;
      checks++; if (a_out_valid !== 1'b1 || a_out_index !== ea[k] || a_out_tag !== et[k] || a_out_last !== (k != 0)) begin
        errors++; $display("FAIL b2b_mode0 beat %0d: v=%b idx=%0d tag=%0d last=%b expected 1 %0d %0d %0d", k, a_out_valid, a_out_index, a_out_tag, a_out_last, ea[k], et[k], k != 0); end
      checks++; if (b_out_valid !== 1'b1 || b_out_index !== eb[k] || b_out_tag !== et[k]) begin
        errors++; $display("FAIL b2b_mode1 beat %0d: v=%b idx=%0d tag=%0d expected 1 %0d %0d", k, b_out_valid, b_out_index, b_out_tag, eb[k], et[k]); end
      checks++; if (a_in_ready !== (k != 0)) begin
        errors++; $display("FAIL b2b_in_ready beat %0d: got %b expected %0d", k, a_in_ready, k != 0); end
    end
    @(negedge clk);
    in_valid = 1'b1; in_mask = 8'h00; in_tag = 4'd9; #1;
    checks++; if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL zero_mask_ready: got %b expected 1", a_in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || b_out_valid !== 1'b0) begin
      errors++; $display("FAIL zero_mask_idle: a_valid=%b a_busy=%b b_valid=%b expected 0 0 0", a_out_valid, a_busy, b_out_valid); end
  endtask

  task automatic test_backpressure;
    logic [3:0] pat = 4'b1001;
    int got = 0;
    bit stalled = 1'b0;
    logic [2:0] prev_a = '0;
    logic [2:0] prev_b = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      in_valid = (c == 0); in_mask = 8'hFF; in_tag = 4'hA;
      out_ready = pat[c % 4]; #1;
      if (a_out_valid) begin
        checks++; if (a_out_index !== got || b_out_index !== 7 - got || a_out_tag !== 4'hA || b_out_tag !== 4'hA) begin
          errors++; $display("FAIL bp_order n=%0d: a=%0d b=%0d tag=%0d expected %0d %0d 10", got, a_out_index, b_out_index, a_out_tag, got, 7 - got); end
        checks++; if (a_out_last !== (got == 7) || b_out_last !== (got == 7)) begin
          errors++; $display("FAIL bp_last n=%0d: a=%b b=%b expected %0d", got, a_out_last, b_out_last, got == 7); end
        if (stalled) begin
          checks++; if (a_out_index !== prev_a || b_out_index !== prev_b) begin
            errors++; $display("FAIL bp_stable: a=%0d b=%0d expected %0d %0d", a_out_index, b_out_index, prev_a, prev_b); end
        end
        prev_a = a_out_index; prev_b = b_out_index;
        stalled = !out_ready;
        if (out_ready) got++;
      end
    end
    checks++; if (got !== 8) begin
      errors++; $display("FAIL bp_count: delivered %0d expected 8", got); end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
    checks++; if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_extra_beat: valid=%b expected 0", a_out_valid); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_valid = 1'b1; in_mask = 8'hF0; in_tag = 4'd2; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      checks++; if (a_out_valid !== 1'b1 || a_out_index !== 4 + k) begin
        errors++; $display("FAIL rmid_beat %0d: v=%b idx=%0d expected 1 %0d", k, a_out_valid, a_out_index, 4 + k); end
    end
    @(negedge clk); out_ready = 1'b0; #2;
    reset = 1'b1; #1;
    checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL rmid_async: a_v=%b b_v=%b busy=%b ready=%b expected 0 0 0 1", a_out_valid, b_out_valid, a_busy, a_in_ready); end
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1 || a_out_tag !== 4'd0) begin
        errors++; $display("FAIL rmid_after %0d: v=%b busy=%b ready=%b tag=%0d expected 0 0 1 0", k, a_out_valid, a_busy, a_in_ready, a_out_tag); end
    end
  endtask

  task automatic test_width1;
    @(negedge clk);
    w_in_valid = 1'b1; w_in_mask = 1'b1; w_in_tag = 4'd9; w_out_ready = 1'b1;
    @(negedge clk);
    w_in_tag = 4'hC; #1;
    checks++; if (w_out_valid !== 1'b1 || w_out_index !== 1'b0 || w_out_last !== 1'b1 || w_out_tag !== 4'd9 || w_in_ready !== 1'b1) begin
      errors++; $display("FAIL w1_beat0: v=%b idx=%0d last=%b tag=%0d ready=%b expected 1 0 1 9 1", w_out_valid, w_out_index, w_out_last, w_out_tag, w_in_ready); end
    @(negedge clk); w_in_valid = 1'b0; #1;
    checks++; if (w_out_valid !== 1'b1 || w_out_last !== 1'b1 || w_out_tag !== 4'hC) begin
      errors++; $display("FAIL w1_beat1: v=%b last=%b tag=%0d expected 1 1 12", w_out_valid, w_out_last, w_out_tag); end
    @(negedge clk); #1;
    checks++; if (w_out_valid !== 1'b0 || w_busy !== 1'b0) begin
      errors++; $display("FAIL w1_idle: v=%b busy=%b expected 0 0", w_out_valid, w_busy); end
  endtask

  task automatic test_random;
    int q0[$];
    int q1[$];
    int acc = 0;
    int exp_v, obs, n, k;
    for (int cyc = 0; cyc < 20000 && (acc < 300 || q0.size() != 0 || q1.size() != 0); cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (acc < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_mask   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      in_tag    = 4'($urandom);
      #1;
      if (a_out_valid && out_ready) begin
        obs = int'(a_out_index) | (int'(a_out_last) << 8) | (int'(a_out_tag) << 9);
        exp_v = (q0.size() != 0) ? q0.pop_front() : -1;
        checks++; if (obs !== exp_v) begin
          errors++; $display("FAIL rand_mode0: beat 0x%0h expected 0x%0h", obs, exp_v); end
      end
      if (b_out_valid && out_ready) begin
        obs = int'(b_out_index) | (int'(b_out_last) << 8) | (int'(b_out_tag) << 9);
        exp_v = (q1.size() != 0) ? q1.pop_front() : -1;
        checks++; if (obs !== exp_v) begin
          errors++; $display("FAIL rand_mode1: beat 0x%0h expected 0x%0h", obs, exp_v); end
      end
      n = $countones(in_mask);
      if (in_valid && a_in_ready) begin
        acc++;
        k = 0;
        for (int i = 0; i < 8; i++) if (in_mask[i]) begin
          q0.push_back(i | (int'(k == n - 1) << 8) | (int'(in_tag) << 9)); k++;
        end
      end
      if (in_valid && b_in_ready) begin
        k = 0;
        for (int i = 7; i >= 0; i--) if (in_mask[i]) begin
          q1.push_back(i | (int'(k == n - 1) << 8) | (int'(in_tag) << 9)); k++;
        end
      end
    end
    checks++; if (q0.size() != 0 || q1.size() != 0 || acc != 300) begin
      errors++; $display("FAIL rand_drain: q0=%0d q1=%0d masks=%0d expected 0 0 300", q0.size(), q1.size(), acc); end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      errors++; $display("FAIL rand_idle: a=%b b=%b expected 0 0", a_out_valid, b_out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_width1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
